// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable clock divider with deferred, glitch-free divisor updates
module clock_divider_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             sq_out,
    output logic             tick,
    output logic [WIDTH-1:0] cnt_out,
    output logic             load_pending,
    output logic             div_err
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt, div_act, div_pend;
    logic             pend_v;
    logic [WIDTH-1:0] cnt_n, div_act_n, nxt_div, hi;
    logic             pend_v_n, tick_n, sq_n, err_n, load_ok, wrap, restart;

    assign load_ok = div_load && div_in != '0;
    assign err_n   = div_load && div_in == '0;
    assign nxt_div = load_ok ? div_in : div_pend;
    assign hi      = div_act - (div_act >> 1);
    assign wrap    = en && cnt == div_act - ONE;
    assign restart = clr || wrap;

    // next state: a same-cycle load joins the pending slot first, so a restart applies the newest divisor
    always_comb begin
        cnt_n     = restart ? '0 : (en ? cnt + ONE : cnt);
        tick_n    = wrap && !clr;
        sq_n      = restart ? 1'b1 : (en ? (cnt + ONE) < hi : sq_out);
        div_act_n = (restart && (load_ok || pend_v)) ? nxt_div : div_act;
        pend_v_n  = !restart && (load_ok || pend_v);
    end

    // state and registered outputs; reset dominates everything including loads
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= DEF;
            div_pend <= DEF;
            pend_v   <= 1'b0;
            tick     <= 1'b0;
            sq_out   <= 1'b1;
            div_err  <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            div_act  <= div_act_n;
            div_pend <= nxt_div;
            pend_v   <= pend_v_n;
            tick     <= tick_n;
            sq_out   <= sq_n;
            div_err  <= err_n;
        end
    end

    assign cnt_out      = cnt;
    assign load_pending = pend_v;
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: randomized and directed checks against a period-level model
module tb_clock_divider_prog;
    localparam int W = 16;
    localparam int DEF = 100;

    logic clk = 0, rst = 0, en = 0, clr = 0, div_load = 0;
    logic [W-1:0] div_in = '0;
    logic sq_out, tick, load_pending, div_err;
    logic [W-1:0] cnt_out;

    int n_chk = 0, n_fail = 0;

    // model: phase within the period, active divisor, newest accepted divisor
    int m_ph, m_dv, m_pd;
    bit m_pv, m_tick, m_err, m_ok = 0, m_ld;

    clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .div_in(div_in), .div_load(div_load),
        .sq_out(sq_out), .tick(tick), .cnt_out(cnt_out), .load_pending(load_pending), .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // model update on each rising edge from the inputs that edge sees
    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_dv = DEF; m_pv = 0; m_tick = 0; m_err = 0; m_ok = 1;
        end else begin
            m_ld  = div_load && div_in != 0;
            m_err = div_load && div_in == 0;
            if (m_ld) begin m_pd = int'(div_in); m_pv = 1; end
            if (clr || (en && m_ph == m_dv - 1)) begin
                m_tick = !clr;
                m_ph = 0;
                if (m_pv) m_dv = m_pd;
                m_pv = 0;
            end else begin
                m_tick = 0;
                if (en) m_ph++;
            end
        end
    end

    // compare every output against the model on every falling edge
    always @(negedge clk) if (m_ok) begin
        chk("cnt_out", int'(cnt_out), m_ph);
        chk("sq_out", int'(sq_out), int'(m_ph < (m_dv + 1) / 2));
        chk("tick", int'(tick), int'(m_tick));
        chk("load_pending", int'(load_pending), int'(m_pv));
        chk("div_err", int'(div_err), int'(m_err));
    end

    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < lim);
        if (!tick) begin
            n_chk++; n_fail++;
            $display("FAIL wait_tick: no tick within %0d cycles", lim);
        end
    endtask

    task automatic run_to(input int v);
        int k = 0;
        while (int'(cnt_out) != v && k < 300) begin @(negedge clk); k++; end
        if (int'(cnt_out) != v) begin
            n_chk++; n_fail++;
            $display("FAIL run_to: cnt_out %0d never reached %0d", cnt_out, v);
        end
    endtask

    task automatic load(input int v);
        div_in = W'(v); div_load = 1;
        @(negedge clk);
        div_load = 0;
    endtask

    initial begin
        int n, hi_cnt;
        int ticks[$];
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; en = 1;
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_sq", int'(sq_out), 1);
        chk("rst_tick", int'(tick), 0);
        chk("rst_lp", int'(load_pending), 0);
        chk("rst_err", int'(div_err), 0);
        hi_cnt = int'(sq_out);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (tick) ticks.push_back(k);
            if (k < 100) hi_cnt += int'(sq_out);
        end
        chk("tick_count", ticks.size(), 3);
        if (ticks.size() == 3) begin
            chk("tick1", ticks[0], 100);
            chk("tick2", ticks[1], 200);
            chk("tick3", ticks[2], 300);
        end
        chk("sq_high_100", hi_cnt, 50);

        run_to(40);
        load(10);
        chk("deferred_lp", int'(load_pending), 1);
        run_to(99);
        chk("deferred_lp_99", int'(load_pending), 1);
        @(negedge clk);
        chk("deferred_tick", int'(tick), 1);
        chk("deferred_lp_clear", int'(load_pending), 0);
        wait_tick(200, n);
        chk("period_10", n, 10);

        load(0);
        chk("err_pulse", int'(div_err), 1);
        @(negedge clk);
        chk("err_gone", int'(div_err), 0);
        chk("err_no_pend", int'(load_pending), 0);
        wait_tick(200, n);
        wait_tick(200, n);
        chk("period_after_err", n, 10);
        load(20);
        load(30);
        wait_tick(200, n);
        wait_tick(200, n);
        chk("period_30", n, 30);

        div_in = W'(100); div_load = 1; clr = 1;
        @(negedge clk);
        div_load = 0; clr = 0;
        chk("clr_load_cnt", int'(cnt_out), 0);
        chk("clr_load_lp", int'(load_pending), 0);
        run_to(60);
        en = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk("hold_cnt", int'(cnt_out), 60);
            chk("hold_sq", int'(sq_out), 0);
            chk("hold_tick", int'(tick), 0);
        end
        en = 1;
        run_to(80);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("clr_cnt", int'(cnt_out), 0);
        chk("clr_sq", int'(sq_out), 1);
        wait_tick(300, n);
        chk("period_after_clr", n, 100);

        load(7);
        clr = 1;
        @(negedge clk);
        clr = 0;
        hi_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            chk("odd_cnt", int'(cnt_out), k);
            hi_cnt += int'(sq_out);
            @(negedge clk);
        end
        chk("odd_high", hi_cnt, 4);
        chk("odd_tick", int'(tick), 1);
        wait_tick(50, n);
        chk("period_7", n, 7);

        div_in = W'(1); div_load = 1; clr = 1;
        @(negedge clk);
        div_load = 0; clr = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("div1_tick", int'(tick), 1);
            chk("div1_sq", int'(sq_out), 1);
            chk("div1_cnt", int'(cnt_out), 0);
        end

        div_in = W'(100); div_load = 1; clr = 1;
        @(negedge clk);
        clr = 0; div_in = W'(50);
        @(negedge clk);
        div_load = 0;
        chk("pend_before_rst", int'(load_pending), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("pend_after_rst", int'(load_pending), 0);
        wait_tick(300, n);
        chk("period_after_rst", n, 100);

        for (int k = 0; k < 3000; k++) begin
            en = $urandom_range(0, 9) != 0;
            div_load = $urandom_range(0, 7) == 0;
            div_in = W'($urandom_range(0, 12));
            clr = $urandom_range(0, 49) == 0;
            rst = $urandom_range(0, 299) == 0;
            @(negedge clk);
        end
        rst = 0; clr = 0; div_load = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
